id_ex_stage: RTL and testbench

- Pipeline register between decode (ID) and execute (EX).
- Resolves RAW hazards by forwarding from EX and MEM, detects load-use hazards, and registers the ALU operands and control for the next cycle.
- Outputs A, B and ALUOp drive the ALU inputs directly. Remaining controls travel on to the EX/MEM register.

---
 rtl/id_ex_stage.sv | 154 +++++++++++++++
 tb/tb_id_ex_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves operand forwarding from EX and MEM, detects
// load-use hazards, and registers ALU operands plus control for the EX stage.
module id_ex_stage #(
    parameter int XLEN = 64,
    parameter int ZR   = 31
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [4:0]      id_rn,
    input  logic [4:0]      id_rm,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_rn_data,
    input  logic [XLEN-1:0] id_rm_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_alu_src,
    input  logic [2:0]      id_alu_op,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    input  logic [XLEN-1:0] alu_result,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_data,
    input  logic            flush,
    output logic            stall,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [2:0]      ALUOp,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_rd,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg
);

    localparam logic [4:0] ZR_IDX = 5'(ZR);

    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] store_data_q, store_data_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      alu_op_q, alu_op_d;
    logic            valid_q, valid_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic            mem_to_reg_q, mem_to_reg_d;

    logic            rm_used;
    logic            hazard;
    logic            load_id;
    logic [XLEN-1:0] fwd_rn;
    logic [XLEN-1:0] fwd_rm;

    // A load in EX has no result yet, so it never qualifies as an EX forward source.
    function automatic logic ex_hit(input logic [4:0] s, input logic v, input logic rw,
                                    input logic mr, input logic [4:0] rd);
        return v && rw && !mr && (rd == s) && (s != ZR_IDX);
    endfunction

    function automatic logic mem_hit(input logic [4:0] s, input logic rw, input logic [4:0] rd);
        return rw && (rd == s) && (s != ZR_IDX);
    endfunction

    always_comb begin
        fwd_rn = id_rn_data;
        if (ex_hit(id_rn, valid_q, reg_write_q, mem_read_q, rd_q))
            fwd_rn = alu_result;
        else if (mem_hit(id_rn, mem_reg_write, mem_rd))
            fwd_rn = mem_data;

        fwd_rm = id_rm_data;
        if (ex_hit(id_rm, valid_q, reg_write_q, mem_read_q, rd_q))
            fwd_rm = alu_result;
        else if (mem_hit(id_rm, mem_reg_write, mem_rd))
            fwd_rm = mem_data;
    end

    always_comb begin
        rm_used = !id_alu_src || id_mem_write;
        hazard  = valid_q && mem_read_q && (rd_q != ZR_IDX) && id_valid &&
                  ((rd_q == id_rn) || (rm_used && (rd_q == id_rm)));
        stall   = hazard && id_valid && !flush;
        load_id = !flush && !stall && id_valid;
    end

    // Bubbles clear control only; data fields keep their last values.
    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        store_data_d = store_data_q;
        rd_d         = rd_q;
        alu_op_d     = 3'b000;
        valid_d      = 1'b0;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        if (load_id) begin
            a_d          = fwd_rn;
            b_d          = id_alu_src ? id_imm : fwd_rm;
            store_data_d = fwd_rm;
            rd_d         = id_rd;
            alu_op_d     = id_alu_op;
            valid_d      = 1'b1;
            reg_write_d  = id_reg_write;
            mem_read_d   = id_mem_read;
            mem_write_d  = id_mem_write;
            mem_to_reg_d = id_mem_to_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            alu_op_q     <= '0;
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            store_data_q <= store_data_d;
            rd_q         <= rd_d;
            alu_op_q     <= alu_op_d;
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    assign A             = a_q;
    assign B             = b_q;
    assign ALUOp         = alu_op_q;
    assign ex_store_data = store_data_q;
    assign ex_rd         = rd_q;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, XZR, load-use and flush.
module tb_id_ex_stage;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid;
    logic [4:0]      id_rn, id_rm, id_rd;
    logic [XLEN-1:0] id_rn_data, id_rm_data, id_imm;
    logic            id_alu_src;
    logic [2:0]      id_alu_op;
    logic            id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic [XLEN-1:0] alu_result;
    logic [4:0]      mem_rd;
    logic            mem_reg_write;
    logic [XLEN-1:0] mem_data;
    logic            flush;
    logic            stall;
    logic [XLEN-1:0] A, B, ex_store_data;
    logic [2:0]      ALUOp;
    logic [4:0]      ex_rd;
    logic            ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.XLEN(XLEN), .ZR(31)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_rn_data(id_rn_data), .id_rm_data(id_rm_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .alu_result(alu_result), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_data(mem_data), .flush(flush), .stall(stall),
        .A(A), .B(B), .ALUOp(ALUOp), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rn = 0; id_rm = 0; id_rd = 0;
        id_rn_data = 0; id_rm_data = 0; id_imm = 0;
        id_alu_src = 0; id_alu_op = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        flush = 0;
    endtask

    task automatic issue(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                         input logic [XLEN-1:0] rnd, input logic [XLEN-1:0] rmd,
                         input logic [XLEN-1:0] imm, input logic src, input logic [2:0] op,
                         input logic rw, input logic mr, input logic mw, input logic m2r);
        id_valid = 1; id_rn = rn; id_rm = rm; id_rd = rd;
        id_rn_data = rnd; id_rm_data = rmd; id_imm = imm;
        id_alu_src = src; id_alu_op = op;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    task automatic test_reset();
        rst_n = 0; idle();
        alu_result = 0; mem_rd = 0; mem_reg_write = 0; mem_data = 0;
        tick(); tick();
        checks++;
        if ({A, B, ALUOp, ex_valid, ex_rd} !== '0) begin
            errors++; $display("FAIL reset_state A=%0h B=%0h op=%0d v=%0b", A, B, ALUOp, ex_valid);
        end
        rst_n = 1;
        issue(5'd2, 5'd3, 5'd1, 64'h5, 64'h6, 0, 0, 3'b001, 1, 0, 0, 0);
        tick();
        checks++;
        if (A !== 64'h5 || ex_valid !== 1'b1) begin
            errors++; $display("FAIL pre_reset_load A=%0h v=%0b want 5 1", A, ex_valid);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (A !== '0 || B !== '0 || ALUOp !== 3'd0 || ex_valid !== 1'b0 || ex_reg_write !== 1'b0 ||
            ex_rd !== 5'd0 || ex_store_data !== '0) begin
            errors++; $display("FAIL async_reset A=%0h B=%0h op=%0d v=%0b rd=%0d want all 0",
                               A, B, ALUOp, ex_valid, ex_rd);
        end
        rst_n = 1;
        issue(5'd2, 5'd3, 5'd1, 64'd7, 64'd9, 0, 0, 3'b010, 1, 0, 0, 0);
        tick();
        checks++;
        if (A !== 64'd7 || B !== 64'd9 || ALUOp !== 3'd2 || ex_valid !== 1'b1 || ex_rd !== 5'd1) begin
            errors++; $display("FAIL first_add A=%0d B=%0d op=%0d v=%0b rd=%0d want 7 9 2 1 1",
                               A, B, ALUOp, ex_valid, ex_rd);
        end
    endtask

    task automatic test_ex_forward();
        issue(5'd9, 5'd9, 5'd1, 0, 0, 0, 0, 3'b010, 1, 0, 0, 0);
        tick();
        alu_result = 64'h10;
        issue(5'd1, 5'd3, 5'd7, 64'hDEAD, 64'h0, 0, 0, 3'b010, 1, 0, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL ex_fwd_stall stall=%0b want 0", stall);
        end
        tick();
        checks++;
        if (A !== 64'h10) begin
            errors++; $display("FAIL ex_forward A=%0h want 10", A);
        end
    endtask

    task automatic test_priority();
        issue(5'd9, 5'd9, 5'd4, 0, 0, 0, 0, 3'b010, 1, 0, 0, 0);
        tick();
        alu_result = 64'hAA; mem_rd = 5'd4; mem_reg_write = 1; mem_data = 64'hBB;
        issue(5'd4, 5'd9, 5'd5, 64'h1, 64'h2, 0, 0, 3'b010, 1, 0, 0, 0);
        tick();
        checks++;
        if (A !== 64'hAA) begin
            errors++; $display("FAIL ex_over_mem A=%0h want aa", A);
        end
        issue(5'd4, 5'd9, 5'd6, 64'h1, 64'h2, 0, 0, 3'b010, 1, 0, 0, 0);
        tick();
        checks++;
        if (A !== 64'hBB) begin
            errors++; $display("FAIL mem_forward A=%0h want bb", A);
        end
        mem_reg_write = 0;
    endtask

    task automatic test_zr();
        issue(5'd9, 5'd9, 5'd31, 0, 0, 0, 0, 3'b010, 1, 0, 0, 0);
        tick();
        alu_result = 64'h77;
        issue(5'd31, 5'd9, 5'd8, 64'h0, 64'h0, 0, 0, 3'b010, 1, 0, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL zr_stall stall=%0b want 0", stall);
        end
        tick();
        checks++;
        if (A !== 64'h0) begin
            errors++; $display("FAIL zr_no_forward A=%0h want 0", A);
        end
        issue(5'd9, 5'd9, 5'd31, 0, 0, 0, 1, 3'b000, 1, 1, 0, 1);
        tick();
        issue(5'd31, 5'd31, 5'd8, 64'h0, 64'h0, 0, 0, 3'b010, 1, 0, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL zr_load_stall stall=%0b want 0", stall);
        end
        tick();
    endtask

    task automatic test_load_use();
        issue(5'd9, 5'd9, 5'd2, 0, 0, 0, 1, 3'b000, 1, 1, 0, 1);
        tick();
        issue(5'd1, 5'd2, 5'd6, 64'd3, 64'h999, 0, 0, 3'b010, 1, 0, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL load_use_stall stall=%0b want 1", stall);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ALUOp !== 3'd0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 ||
            ex_rd !== 5'd2) begin
            errors++; $display("FAIL bubble v=%0b op=%0d rw=%0b mr=%0b rd=%0d want 0 0 0 0 2",
                               ex_valid, ALUOp, ex_reg_write, ex_mem_read, ex_rd);
        end
        mem_rd = 5'd2; mem_reg_write = 1; mem_data = 64'h1234;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL stall_release stall=%0b want 0", stall);
        end
        tick();
        checks++;
        if (B !== 64'h1234 || A !== 64'd3 || ex_store_data !== 64'h1234 || ex_valid !== 1'b1 ||
            ALUOp !== 3'd2) begin
            errors++; $display("FAIL load_use_fwd A=%0h B=%0h sd=%0h v=%0b op=%0d want 3 1234 1234 1 2",
                               A, B, ex_store_data, ex_valid, ALUOp);
        end
        mem_reg_write = 0;
    endtask

    task automatic test_flush();
        issue(5'd9, 5'd9, 5'd2, 0, 0, 0, 1, 3'b000, 1, 1, 0, 1);
        tick();
        issue(5'd1, 5'd2, 5'd6, 64'd3, 64'h5, 0, 0, 3'b010, 1, 0, 0, 0);
        flush = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL flush_stall stall=%0b want 0", stall);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ALUOp !== 3'd0 || ex_reg_write !== 1'b0) begin
            errors++; $display("FAIL flush_bubble v=%0b op=%0d rw=%0b want 0 0 0", ex_valid, ALUOp, ex_reg_write);
        end
        flush = 0;
        issue(5'd9, 5'd9, 5'd2, 0, 0, 0, 1, 3'b000, 1, 1, 0, 1);
        tick();
        issue(5'd1, 5'd2, 5'd0, 64'd3, 64'h5, 64'hFFFF_FFFF_FFFF_FFF8, 1, 3'b000, 0, 0, 1, 0);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL store_rm_stall stall=%0b want 1", stall);
        end
        issue(5'd1, 5'd2, 5'd6, 64'd3, 64'h5, 64'hFFFF_FFFF_FFFF_FFF8, 1, 3'b010, 1, 0, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL imm_no_stall stall=%0b want 0", stall);
        end
        tick();
        checks++;
        if (B !== 64'hFFFF_FFFF_FFFF_FFF8 || ex_valid !== 1'b1) begin
            errors++; $display("FAIL imm_operand B=%0h v=%0b want fffffffffffffff8 1", B, ex_valid);
        end
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_priority();
        test_zr();
        test_load_use();
        test_flush();
        idle();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
